// File: rtl/decoder_scan_ctrl_if.sv
// Control and decoder-drive bundle between a scan master and decoder_scan_ctrl.
// The slave modport is the sequencer; the master modport drives start/stop and the scan setup.
interface decoder_scan_ctrl_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               mode;
  logic [7:0]         ch_mask;
  logic [DWELL_W-1:0] dwell;
  logic               A2;
  logic               A1;
  logic               A0;
  logic               E1_n;
  logic               E2_n;
  logic               E3;
  logic               busy;
  logic               ch_tick;
  logic               done;

  modport master (
    output start, stop, mode, ch_mask, dwell,
    input  A2, A1, A0, E1_n, E2_n, E3, busy, ch_tick, done
  );

  modport slave (
    input  start, stop, mode, ch_mask, dwell,
    output A2, A1, A0, E1_n, E2_n, E3, busy, ch_tick, done
  );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Scans the enabled channels of a latched mask in ascending order, holding each for a dwell time.
// Outputs registered; one-cycle break-before-make gap between channels; stop aborts without done.
module decoder_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  decoder_scan_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  state_t             state_q, state_d;
  logic [2:0]         addr_q, addr_d;
  logic [7:0]         mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;

  logic [3:0]         start_hit;
  logic [3:0]         above_hit;
  logic [3:0]         wrap_hit;
  logic [2:0]         next_ch;

  // Returns {found, index} of the lowest set bit of m at or above position from.
  function automatic logic [3:0] find_set(input logic [7:0] m, input logic [3:0] from);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i >= int'(from))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  always_comb begin
    start_hit = find_set(bus.ch_mask, 4'd0);
    above_hit = find_set(mask_q, {1'b0, addr_q} + 4'd1);
    wrap_hit  = find_set(mask_q, 4'd0);
    next_ch   = above_hit[3] ? above_hit[2:0] : wrap_hit[2:0];

    state_d = state_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    busy_d  = 1'b0;
    tick_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop && start_hit[3]) begin
          mask_d  = bus.ch_mask;
          dwell_d = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
          addr_d  = start_hit[2:0];
          cnt_d   = DWELL_W'(1);
          state_d = ACTIVE;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          tick_d  = 1'b1;
        end
      end
      ACTIVE: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (cnt_q == dwell_q) begin
          // mode is only consulted here, at the end of each channel.
          if (above_hit[3] || !bus.mode) begin
            state_d = GAP;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q + DWELL_W'(1);
          en_d   = 1'b1;
          busy_d = 1'b1;
        end
      end
      GAP: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else begin
          addr_d  = next_ch;
          cnt_d   = DWELL_W'(1);
          state_d = ACTIVE;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          tick_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 3'd0;
      mask_q  <= 8'd0;
      dwell_q <= DWELL_W'(1);
      cnt_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign bus.A2      = addr_q[2];
  assign bus.A1      = addr_q[1];
  assign bus.A0      = addr_q[0];
  assign bus.E3      = en_q;
  assign bus.E1_n    = ~en_q;
  assign bus.E2_n    = ~en_q;
  assign bus.busy    = busy_q;
  assign bus.ch_tick = tick_q;
  assign bus.done    = done_q;
endmodule
